rr_byte_tx: RTL



---
 rtl/rr_byte_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rr_byte_tx.sv
// RR interval byte transmitter: buffers 12-bit intervals in a small FIFO and
// emits each one as a two-byte frame {SYNC, rr[11:8]}, rr[7:0] on an 8-bit bus.
module rr_byte_tx #(
  parameter int          DEPTH      = 4,
  parameter int          GAP_CYCLES = 2,
  parameter logic [3:0]  SYNC       = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [11:0] in_rr,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [7:0]  frame_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HI   = 2'd1;
  localparam logic [1:0] LO   = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [11:0]   hold_q, hold_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [GW-1:0] gap_q, gap_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full && !flush;

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    state_d       = state_q;
    hold_d        = hold_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    tx_last_d     = tx_last_q;
    frame_count_d = frame_count_q;
    gap_d         = gap_q;
    pop           = 1'b0;

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      gap_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            hold_d     = mem_q[rptr_q];
            tx_data_d  = {SYNC, mem_q[rptr_q][11:8]};
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            state_d    = HI;
          end
        end
        HI: begin
          if (tx_ready) begin
            tx_data_d = hold_q[7:0];
            tx_last_d = 1'b1;
            state_d   = LO;
          end else begin
            tx_data_d = {SYNC, hold_q[11:8]};
          end
        end
        LO: begin
          if (tx_ready) begin
            frame_count_d = frame_count_q + 8'd1;
            tx_valid_d    = 1'b0;
            tx_last_d     = 1'b0;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = GAP;
            end
          end
        end
        GAP: begin
          // The gap state occupies exactly GAP_CYCLES cycles before IDLE.
          if (gap_q <= GW'(1)) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_rr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      hold_q        <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      frame_count_q <= '0;
      gap_q         <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_last_q     <= tx_last_d;
      frame_count_q <= frame_count_d;
      gap_q         <= gap_d;
    end
  end

  assign in_ready    = !full;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != IDLE) || !empty;

endmodule
